// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared light codes, phase encoding, direction indices and the
//            light-bus formatting helper for the traffic phase scheduler.
// Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_e;

    // Only the owning direction's field can be non-red; all others stay 00.
    function automatic logic [7:0] light_word(input phase_e ph, input logic [1:0] dir);
        logic [1:0] code;
        logic [7:0] word;
        case (ph)
            PH_GREEN:  code = LIGHT_GREEN;
            PH_YELLOW: code = LIGHT_YELLOW;
            default:   code = LIGHT_RED;
        endcase
        word = 8'h00;
        word[{dir, 1'b0} +: 2] = code;
        return word;
    endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_phase_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler_if
// Purpose  : Sensor/preempt inputs and light/phase outputs of the scheduler.
//            master = scheduler side, slave = intersection/display side.
// Revision : 1.0  initial release
// ============================================================================
interface traffic_phase_scheduler_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       sensor_1th;
    logic [3:0]       sensor_5th;
    logic [3:0]       preempt_req;
    logic [7:0]       light;
    logic [1:0]       active_dir;
    logic [1:0]       phase;
    logic [CNT_W-1:0] phase_count;
    logic             preempt_ack;

    modport master (
        input  sensor_1th, sensor_5th, preempt_req,
        output light, active_dir, phase, phase_count, preempt_ack
    );

    modport slave (
        output sensor_1th, sensor_5th, preempt_req,
        input  light, active_dir, phase, phase_count, preempt_ack
    );
endinterface : traffic_phase_scheduler_if
`default_nettype wire

// File: rtl/traffic_phase_scheduler_rr_dir_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_dir_picker
// Purpose  : Combinational 4-way rotating priority pick. Scans last+1 .. last+4
//            (mod 4) and grants the first requester. With no request the grant
//            is last+1 so the rotation always advances. last=3 gives plain
//            lowest-index-first priority.
// Revision : 1.0  initial release
// ============================================================================
module rr_dir_picker (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant_dir,
    output logic       any
);

    logic [1:0] cand;

    // Scan farthest-first so the nearest requester after 'last' overwrites.
    always_comb begin
        any       = |req;
        grant_dir = last + 2'd1;
        cand      = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                grant_dir = cand;
            end
        end
    end

endmodule : rr_dir_picker
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler
// Purpose  : Four-way intersection sequencer. One approach at a time runs
//            GREEN -> YELLOW -> ALL_RED; next approach chosen by emergency
//            preempt, then sensor-weighted round robin.
// Revision : 1.0  initial release
// ============================================================================
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_LONG   = 60,
    parameter int GREEN_MID    = 40,
    parameter int GREEN_SHORT  = 20,
    parameter int YELLOW_TIME  = 5,
    parameter int ALL_RED_TIME = 2,
    parameter int CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    traffic_phase_scheduler_if.master bus
);

    localparam logic [CNT_W-1:0] green_long_m1  = CNT_W'(GREEN_LONG - 1);
    localparam logic [CNT_W-1:0] green_mid_m1   = CNT_W'(GREEN_MID - 1);
    localparam logic [CNT_W-1:0] green_short_m1 = CNT_W'(GREEN_SHORT - 1);
    localparam logic [CNT_W-1:0] yellow_m1      = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] allred_m1      = CNT_W'(ALL_RED_TIME - 1);

    // Registered input copies; every decision uses these.
    logic [3:0]       s1_q;
    logic [3:0]       s5_q;
    logic [3:0]       pr_q;

    phase_e           phase_q;
    phase_e           phase_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [1:0]       dir_q;
    logic [1:0]       dir_nxt;
    logic [7:0]       light_q;
    logic             ack_q;

    logic [1:0]       pre_dir;
    logic             pre_any;
    logic [1:0]       seq_dir;
    logic             seq_any;
    logic [1:0]       next_dir;
    logic [3:0]       dir_mask;
    logic             other_preempt;

    // Green length is fixed from the sensors seen at selection time.
    function automatic logic [CNT_W-1:0] green_len_m1(input logic s1, input logic s5);
        if (s1 && s5) begin
            return green_long_m1;
        end else if (s1) begin
            return green_mid_m1;
        end
        return green_short_m1;
    endfunction

    // Emergency path: fixed lowest-index priority (last = W makes N first).
    rr_dir_picker u_pre_pick (
        .req       (pr_q),
        .last      (DIR_W),
        .grant_dir (pre_dir),
        .any       (pre_any)
    );

    // Demand path: rotate from the direction that held the last green.
    rr_dir_picker u_seq_pick (
        .req       (s1_q),
        .last      (dir_q),
        .grant_dir (seq_dir),
        .any       (seq_any)
    );

    assign next_dir      = pre_any ? pre_dir : (seq_any ? seq_dir : dir_q + 2'd1);
    assign dir_mask      = 4'b0001 << dir_q;
    assign other_preempt = |(pr_q & ~dir_mask);

    // Input sampling stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 4'h0;
            s5_q <= 4'h0;
            pr_q <= 4'h0;
        end else begin
            s1_q <= bus.sensor_1th;
            s5_q <= bus.sensor_5th;
            pr_q <= bus.preempt_req;
        end
    end

    // Phase sequencing: next phase, count and owning direction.
    always_comb begin
        phase_nxt = phase_q;
        count_nxt = count_q;
        dir_nxt   = dir_q;
        case (phase_q)
            PH_ALLRED: begin
                if (count_q == '0) begin
                    phase_nxt = PH_GREEN;
                    dir_nxt   = next_dir;
                    count_nxt = green_len_m1(s1_q[next_dir], s5_q[next_dir]);
                end else begin
                    count_nxt = count_q - 1'b1;
                end
            end
            PH_GREEN: begin
                if (other_preempt) begin
                    // A conflicting emergency cuts the green short at once.
                    phase_nxt = PH_YELLOW;
                    count_nxt = yellow_m1;
                end else if (count_q == '0) begin
                    if (!pr_q[dir_q]) begin
                        phase_nxt = PH_YELLOW;
                        count_nxt = yellow_m1;
                    end
                    // else: own emergency pending, hold green at count 0
                end else begin
                    count_nxt = count_q - 1'b1;
                end
            end
            PH_YELLOW: begin
                if (count_q == '0) begin
                    phase_nxt = PH_ALLRED;
                    count_nxt = allred_m1;
                end else begin
                    count_nxt = count_q - 1'b1;
                end
            end
            default: begin
                phase_nxt = PH_ALLRED;
                count_nxt = allred_m1;
            end
        endcase
    end

    // State and output registers; light/ack are formed from the next state so
    // they line up with the registered phase/direction they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_ALLRED;
            count_q <= allred_m1;
            dir_q   <= DIR_W;
            light_q <= 8'h00;
            ack_q   <= 1'b0;
        end else begin
            phase_q <= phase_nxt;
            count_q <= count_nxt;
            dir_q   <= dir_nxt;
            light_q <= light_word(phase_nxt, dir_nxt);
            ack_q   <= (phase_nxt == PH_GREEN) && bus.preempt_req[dir_nxt];
        end
    end

    assign bus.light       = light_q;
    assign bus.active_dir  = dir_q;
    assign bus.phase       = phase_q;
    assign bus.phase_count = count_q;
    assign bus.preempt_ack = ack_q;

endmodule : traffic_phase_scheduler
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_scheduler
// Purpose  : Self-checking bench for traffic_phase_scheduler: behavioural
//            model compared every cycle, plus directed scenarios with
//            hand-computed green lengths, directions and gaps.
// Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int GL = 60;
    localparam int GM = 40;
    localparam int GS = 20;
    localparam int YT = 5;
    localparam int AR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    traffic_phase_scheduler_if #(.CNT_W(8)) bus ();

    traffic_phase_scheduler #(
        .GREEN_LONG   (GL),
        .GREEN_MID    (GM),
        .GREEN_SHORT  (GS),
        .YELLOW_TIME  (YT),
        .ALL_RED_TIME (AR),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phase as 0=all-red,1=green,2=yellow, remaining
    // cycles minus one, owning direction, and the one-cycle-late inputs.
    // ------------------------------------------------------------------
    typedef struct {
        int         ph;
        int         left;
        int         dir;
        logic [3:0] s1;
        logic [3:0] s5;
        logic [3:0] pr;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t mreset();
        mstate_t r;
        r.ph = 0; r.left = AR - 1; r.dir = 3;
        r.s1 = 4'h0; r.s5 = 4'h0; r.pr = 4'h0;
        return r;
    endfunction

    function automatic int pick_dir(mstate_t c);
        int nd;
        nd = -1;
        if (c.pr != 4'h0) begin
            for (int i = 0; i < 4; i++)
                if (nd < 0 && c.pr[i]) nd = i;
        end else begin
            for (int k = 1; k <= 4; k++)
                if (nd < 0 && c.s1[(c.dir + k) % 4]) nd = (c.dir + k) % 4;
            if (nd < 0) nd = (c.dir + 1) % 4;
        end
        return nd;
    endfunction

    function automatic mstate_t mstep(mstate_t c, logic [3:0] s1, logic [3:0] s5, logic [3:0] pr);
        mstate_t n;
        int      nd;
        bit      other;
        n = c; n.s1 = s1; n.s5 = s5; n.pr = pr;
        if (c.ph == 0) begin
            if (c.left > 0) n.left = c.left - 1;
            else begin
                nd = pick_dir(c);
                n.ph = 1; n.dir = nd;
                n.left = ((c.s1[nd] && c.s5[nd]) ? GL : (c.s1[nd] ? GM : GS)) - 1;
            end
        end else if (c.ph == 1) begin
            other = 0;
            for (int i = 0; i < 4; i++)
                if (i != c.dir && c.pr[i]) other = 1;
            if (other) begin n.ph = 2; n.left = YT - 1; end
            else if (c.left > 0) n.left = c.left - 1;
            else if (!c.pr[c.dir]) begin n.ph = 2; n.left = YT - 1; end
        end else begin
            if (c.left > 0) n.left = c.left - 1;
            else begin n.ph = 0; n.left = AR - 1; end
        end
        return n;
    endfunction

    function automatic logic [7:0] exp_light(mstate_t c);
        logic [7:0] w;
        w = 8'h00;
        w[2*c.dir +: 2] = (c.ph == 1) ? 2'b01 : ((c.ph == 2) ? 2'b10 : 2'b00);
        return w;
    endfunction

    // Model advances with the DUT clock and resets with it asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mreset();
        else        m <= mstep(m, bus.sensor_1th, bus.sensor_5th, bus.preempt_req);
    end

    // Every-cycle comparison plus safety invariants.
    int cyc        = 0;
    int green_end  = -1000;
    bit prev_green = 0;
    always @(negedge clk) begin
        int nonred;
        cyc++;
        check("light",       bus.light,       exp_light(m));
        check("phase",       bus.phase,       m.ph);
        check("active_dir",  bus.active_dir,  m.dir);
        check("phase_count", bus.phase_count, m.left);
        check("preempt_ack", bus.preempt_ack, (m.ph == 1) && m.pr[m.dir]);
        nonred = 0;
        for (int d = 0; d < 4; d++) begin
            if (bus.light[2*d +: 2] != 2'b00) nonred++;
            if (bus.light[2*d +: 2] === 2'b11) check("light_code_11", 1, 0);
        end
        check("one_nonred", (nonred <= 1), 1);
        if (!rst_n) begin
            green_end  = -1000;
            prev_green = 0;
        end else begin
            if (bus.phase == PH_GREEN && !prev_green && green_end > -1000)
                check("green_gap", (cyc - green_end) >= (YT + AR), 1);
            if (bus.phase != PH_GREEN && prev_green) green_end = cyc;
            prev_green = (bus.phase == PH_GREEN);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_reset(input logic [3:0] s1, input logic [3:0] s5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.sensor_1th  = s1;
        bus.sensor_5th  = s5;
        bus.preempt_req = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_green(output int dir, output int waited);
        waited = 0;
        dir    = -1;
        while (waited < 300) begin
            @(negedge clk);
            waited++;
            if (bus.phase == PH_GREEN) break;
        end
        if (bus.phase != PH_GREEN) check("wait_green_timeout", 0, 1);
        dir = int'(bus.active_dir);
    endtask

    task automatic green_len(output int len);
        len = 1;
        while (len < 400) begin
            @(negedge clk);
            if (bus.phase != PH_GREEN) break;
            len++;
        end
        if (len >= 400) check("green_len_timeout", 0, 1);
    endtask

    task automatic expect_green(input string tag, input int edir, input int ewait, input int elen);
        int d, w, l;
        wait_green(d, w);
        check({tag, "_dir"}, d, edir);
        check({tag, "_wait"}, w, ewait);
        green_len(l);
        check({tag, "_len"}, l, elen);
    endtask

    initial begin
        int d, w, guard;
        bus.sensor_1th  = 4'h0;
        bus.sensor_5th  = 4'h0;
        bus.preempt_req = 4'h0;
        #1 rst_n = 1'b0;

        // Idle rotation: N,E,S,W,N at 20 cycles, 7 non-green cycles between.
        do_reset(4'h0, 4'h0);
        check("rst_phase_count", bus.phase_count, AR - 1);
        expect_green("idle_n0", 0, 2, GS);
        expect_green("idle_e",  1, 7, GS);
        expect_green("idle_s",  2, 7, GS);
        expect_green("idle_w",  3, 7, GS);
        expect_green("idle_n1", 0, 7, GS);

        // South with both sensors: long green, repeated for S.
        do_reset(4'b0100, 4'b0100);
        expect_green("s_long0", 2, 2, GL);
        expect_green("s_long1", 2, 7, GL);
        expect_green("s_long2", 2, 7, GL);

        // East and west 1st-position demand: alternate at mid length.
        do_reset(4'b1010, 4'h0);
        expect_green("ew_e0", 1, 2, GM);
        expect_green("ew_w0", 3, 7, GM);
        expect_green("ew_e1", 1, 7, GM);
        expect_green("ew_w1", 3, 7, GM);

        // Preemption by west during a 40-cycle north green.
        do_reset(4'b0001, 4'h0);
        wait_green(d, w);
        check("pre_first_dir", d, 0);
        guard = 0;
        while (bus.phase_count != 8'd29 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("pre_reach_29", bus.phase_count, 29);
        bus.preempt_req = 4'b1000;
        @(negedge clk);
        check("pre_still_green", bus.phase, PH_GREEN);
        @(negedge clk);
        check("pre_cut_yellow", bus.phase, PH_YELLOW);
        check("pre_cut_dir", bus.active_dir, 0);
        wait_green(d, w);
        check("pre_w_dir", d, 3);
        check("pre_w_wait", w, YT + AR);
        check("pre_w_ack", bus.preempt_ack, 1);
        repeat (30) @(negedge clk);
        check("pre_hold_green", bus.phase, PH_GREEN);
        check("pre_hold_count", bus.phase_count, 0);
        check("pre_hold_ack", bus.preempt_ack, 1);
        bus.preempt_req = 4'h0;
        @(negedge clk);
        check("pre_rel_green", bus.phase, PH_GREEN);
        check("pre_rel_ack", bus.preempt_ack, 0);
        @(negedge clk);
        check("pre_rel_yellow", bus.phase, PH_YELLOW);

        // Reset asserted mid-yellow forces all-red immediately.
        do_reset(4'h0, 4'h0);
        expect_green("mr_n0", 0, 2, GS);
        @(negedge clk);
        check("mr_in_yellow", bus.phase, PH_YELLOW);
        #2 rst_n = 1'b0;
        #1;
        check("mr_light", bus.light, 8'h00);
        check("mr_phase", bus.phase, PH_ALLRED);
        check("mr_dir", bus.active_dir, 3);
        check("mr_ack", bus.preempt_ack, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_green("mr_n1", 0, 2, GS);
        expect_green("mr_e1", 1, 7, GS);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_traffic_phase_scheduler
`default_nettype wire
